// File: rtl/fp_sub_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : fp_sub_result_stage
// Description : Registered result stage behind a combinational fp32
//               subtractor. It captures operands and the raw difference,
//               overrides IEEE-754 special cases and exponent underflow,
//               and queues the finished results in an in-order FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_sub_result_stage #(
  parameter int          DEPTH = 4,
  parameter logic [31:0] QNAN  = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] raw_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 36;

  // Occupancy needs one spare bit so count + s1_v can never wrap.
  localparam logic [CNT_W:0] C_DEPTH_OCC = (CNT_W + 1)'(DEPTH);

  // Flag bit positions inside the 4-bit flags word.
  localparam int F_NAN  = 3;
  localparam int F_INF  = 2;
  localparam int F_ZERO = 1;
  localparam int F_UNF  = 0;

  // Stage-1 capture register.
  logic        s1_v_q,   s1_v_d;
  logic [31:0] s1_a_q,   s1_a_d;
  logic [31:0] s1_b_q,   s1_b_d;
  logic [31:0] s1_raw_q, s1_raw_d;

  // Output FIFO state.
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];

  // Handshake and classification wires.
  logic           w_accept;
  logic           w_push;
  logic           w_pop;
  logic [CNT_W:0] w_occupancy;
  logic [31:0]    w_cls_result;
  logic [3:0]     w_cls_flags;

  // Operand field decode for the stage-1 contents.
  logic [7:0]  w_ea, w_eb, w_er, w_emax;
  logic [22:0] w_fa, w_fb;
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_flz, w_b_flz;

  // Handshake: the stage may accept whenever a slot is free now or is being
  // freed by a pop this cycle; stage 1 always drains into the FIFO next edge
  // because occupancy never exceeds DEPTH.
  always_comb begin
    w_occupancy = (CNT_W + 1)'(count_q) + (CNT_W + 1)'(s1_v_q);
    out_valid   = (count_q != '0);
    w_pop       = out_valid && out_ready;
    in_ready    = !rst && ((w_occupancy < C_DEPTH_OCC) || w_pop);
    w_accept    = in_valid && in_ready;
    w_push      = s1_v_q;
  end

  // Field decode of the captured operands and raw difference.
  always_comb begin
    w_ea    = s1_a_q[30:23];
    w_eb    = s1_b_q[30:23];
    w_er    = s1_raw_q[30:23];
    w_fa    = s1_a_q[22:0];
    w_fb    = s1_b_q[22:0];
    w_emax  = (w_ea > w_eb) ? w_ea : w_eb;
    w_a_nan = (w_ea == 8'hFF) && (w_fa != '0);
    w_b_nan = (w_eb == 8'hFF) && (w_fb != '0);
    w_a_inf = (w_ea == 8'hFF) && (w_fa == '0);
    w_b_inf = (w_eb == 8'hFF) && (w_fb == '0);
    w_a_flz = (w_ea == 8'h00);
    w_b_flz = (w_eb == 8'h00);
  end

  // Special-case override in priority order; denormals are flushed to zero
  // and a raw exponent above both inputs means the subtractor's normaliser
  // wrapped below zero, so it is reported as underflow.
  always_comb begin
    w_cls_result = s1_raw_q;
    w_cls_flags  = 4'b0000;
    if (w_a_nan || w_b_nan) begin
      w_cls_result       = QNAN;
      w_cls_flags[F_NAN] = 1'b1;
    end else if (w_a_inf && w_b_inf) begin
      w_cls_result       = QNAN;
      w_cls_flags[F_NAN] = 1'b1;
    end else if (w_a_inf) begin
      w_cls_result       = s1_a_q;
      w_cls_flags[F_INF] = 1'b1;
    end else if (w_b_inf) begin
      w_cls_result       = {~s1_b_q[31], s1_b_q[30:0]};
      w_cls_flags[F_INF] = 1'b1;
    end else if (w_a_flz && w_b_flz) begin
      w_cls_result        = 32'h00000000;
      w_cls_flags[F_ZERO] = 1'b1;
    end else if (w_b_flz) begin
      w_cls_result = s1_a_q;
    end else if (w_a_flz) begin
      w_cls_result = {~s1_b_q[31], s1_b_q[30:0]};
    end else if (s1_a_q[30:0] == s1_b_q[30:0]) begin
      w_cls_result        = 32'h00000000;
      w_cls_flags[F_ZERO] = 1'b1;
    end else if ((w_er == 8'h00) || (w_er > w_emax)) begin
      w_cls_result        = 32'h00000000;
      w_cls_flags[F_ZERO] = 1'b1;
      w_cls_flags[F_UNF]  = 1'b1;
    end
  end

  // Stage-1 next state: capture on accept, otherwise empty after the drain.
  always_comb begin
    s1_v_d   = w_accept;
    s1_a_d   = s1_a_q;
    s1_b_d   = s1_b_q;
    s1_raw_d = s1_raw_q;
    if (w_accept) begin
      s1_a_d   = a;
      s1_b_d   = b;
      s1_raw_d = raw_result;
    end
  end

  // FIFO next state: write classified entry, advance pointers, track count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) begin
      mem_d[wr_ptr_q] = {w_cls_flags, w_cls_result};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Head presentation; outputs read zero whenever the FIFO is empty.
  always_comb begin
    result = 32'h00000000;
    flags  = 4'b0000;
    if (out_valid) begin
      result = mem_q[rd_ptr_q][31:0];
      flags  = mem_q[rd_ptr_q][35:32];
    end
  end

  // State register for stage 1 and the FIFO, cleared synchronously.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_raw_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      s1_v_q   <= s1_v_d;
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
      s1_raw_q <= s1_raw_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_sub_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_sub_result_stage
// Description : Self-checking bench for fp_sub_result_stage. A reference
//               model derived from the IEEE-754 override rules and a
//               transaction queue predict every output cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_sub_result_stage;

  localparam int          DEPTH = 4;
  localparam logic [31:0] QNAN  = 32'h7FC00000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] raw_result = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [3:0]  flags;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int last_acc = 0;

  // Expected entries ({flags, result}) and the cycle each was accepted.
  logic [35:0] exp_q[$];
  int          cyc_q[$];

  logic        hold = 1'b0;
  logic [31:0] hold_r = '0;
  logic [3:0]  hold_f = '0;

  fp_sub_result_stage #(.DEPTH(DEPTH), .QNAN(QNAN)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .raw_result (raw_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .flags      (flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference behaviour of a - b after override, as {nan,inf,zero,unf, value}.
  function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] raw);
    bit x_nan, y_nan, x_inf, y_inf, x_den, y_den;
    int ex, ey, er;
    logic [31:0] neg_y;
    ex    = int'(x[30:23]);
    ey    = int'(y[30:23]);
    er    = int'(raw[30:23]);
    x_nan = (ex == 255) && (x[22:0] != 0);
    y_nan = (ey == 255) && (y[22:0] != 0);
    x_inf = (ex == 255) && (x[22:0] == 0);
    y_inf = (ey == 255) && (y[22:0] == 0);
    x_den = (ex == 0);
    y_den = (ey == 0);
    neg_y = y ^ 32'h80000000;
    if (x_nan || y_nan)      return {4'b1000, QNAN};
    if (x_inf && y_inf)      return {4'b1000, QNAN};
    if (x_inf)               return {4'b0100, x};
    if (y_inf)               return {4'b0100, neg_y};
    if (x_den && y_den)      return {4'b0010, 32'h0};
    if (y_den)               return {4'b0000, x};
    if (x_den)               return {4'b0000, neg_y};
    if (x[30:0] == y[30:0])  return {4'b0010, 32'h0};
    if (er == 0 || er > ((ex > ey) ? ex : ey)) return {4'b0011, 32'h0};
    return {4'b0000, raw};
  endfunction

  // Cycle-by-cycle compare of handshake, ordering, data and hold stability.
  always @(negedge clk) begin
    logic exp_ov, exp_ir;
    logic [35:0] e;
    if (rst) begin
      check("in_ready_in_reset", in_ready, 1'b0);
      exp_q.delete();
      cyc_q.delete();
      hold = 1'b0;
    end else begin
      exp_ov = (exp_q.size() > 0) && (cyc_q[0] + 2 <= cyc);
      exp_ir = (exp_q.size() < DEPTH) || (exp_ov && out_ready);
      check("out_valid", out_valid, exp_ov);
      check("in_ready", in_ready, exp_ir);
      if (hold) begin
        check("hold_result", result, hold_r);
        check("hold_flags", flags, hold_f);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          void'(cyc_q.pop_front());
          check("pop_result", result, e[31:0]);
          check("pop_flags", flags, e[35:32]);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, raw_result));
        cyc_q.push_back(cyc);
        last_acc = cyc;
      end
      hold   = out_valid && !out_ready;
      hold_r = result;
      hold_f = flags;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one vector and hold it until accepted (bounded).
  task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic [31:0] vr);
    int n;
    a = va; b = vb; raw_result = vr; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      tick();
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int n_acc, n, seen;
    logic [31:0] va [6];

    // Reset state.
    rst = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_result", result, 32'h0);
    check("reset_flags", flags, 4'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", in_ready, 1'b1);
    tick();

    // Pin the model on hand-computed vectors.
    check("m_normal", model(32'h3F800000, 32'h3F000000, 32'h3F000000), {4'b0000, 32'h3F000000});
    check("m_equal",  model(32'h40400000, 32'h40400000, 32'h12345678), {4'b0010, 32'h00000000});
    check("m_infinf", model(32'h7F800000, 32'h7F800000, 32'h0),        {4'b1000, 32'h7FC00000});
    check("m_ainf",   model(32'h7F800000, 32'h3F800000, 32'h0),        {4'b0100, 32'h7F800000});
    check("m_azero",  model(32'h00000000, 32'h40000000, 32'h0),        {4'b0000, 32'hC0000000});
    check("m_unf",    model(32'h00800001, 32'h00800000, 32'hFF000000), {4'b0011, 32'h00000000});
    check("m_binf",   model(32'h3F800000, 32'hFF800000, 32'h0),        {4'b0100, 32'h7F800000});
    check("m_nan",    model(32'h7F800001, 32'h3F800000, 32'h0),        {4'b1000, 32'h7FC00000});

    // Single transaction latency.
    out_ready = 1'b1;
    send(32'h3F800000, 32'h3F000000, 32'h3F000000);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("latency", 64'(cyc - last_acc), 64'd2);
    check("t1_result", result, 32'h3F000000);
    check("t1_flags", flags, 4'b0000);
    tick();

    // Back-to-back special cases.
    send(32'h40400000, 32'h40400000, 32'hDEADBEEF);
    send(32'h7F800000, 32'h7F800000, 32'h0);
    send(32'h7F800000, 32'h3F800000, 32'h0);
    send(32'h00000000, 32'h40000000, 32'h0);
    send(32'h00800001, 32'h00800000, 32'hFF000000);
    send(32'h3F800000, 32'hFF800000, 32'h0);
    send(32'h7F800001, 32'h3F800000, 32'h0);
    send(32'h40000000, 32'h00000005, 32'h0);
    send(32'h00000003, 32'h80000000, 32'h0);
    send(32'h40400000, 32'h3F800000, 32'h40000000);
    send(32'h00800002, 32'h00800001, 32'h00000001);
    drain();

    // Fill with consumer stalled: exactly DEPTH accepted.
    out_ready = 1'b0;
    va = '{32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000, 32'h41500000};
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      a = va[n_acc]; b = 32'h3F800000; raw_result = va[n_acc] - 32'h00100000;
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) n_acc++;
      tick();
    end
    in_valid = 1'b0;
    check("fill_accepts", 64'(n_acc), 64'(DEPTH));
    @(negedge clk);
    check("full_not_ready", in_ready, 1'b0);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("ready_on_first_pop", in_ready, 1'b1);
    check("valid_on_first_pop", out_valid, 1'b1);
    tick();
    drain();

    // Reset with three buffered entries and stage 1 occupied.
    out_ready = 1'b0;
    send(32'h40800000, 32'h3F800000, 32'h40400000);
    send(32'h40A00000, 32'h3F800000, 32'h40800000);
    send(32'h40C00000, 32'h3F800000, 32'h40A00000);
    send(32'h40E00000, 32'h3F800000, 32'h40C00000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_out_valid", out_valid, 1'b0);
    check("rst_mid_in_ready", in_ready, 1'b1);
    tick();
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
      tick();
    end
    check("no_stale_output", 64'(seen), 64'd0);
    send(32'h3F800000, 32'h3F000000, 32'h3F000000);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
